// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, shift func3 codes, bundles.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] j;
        logic [31:0] u;
    } imm_t;

    typedef struct packed {
        logic        is_store;
        logic        is_load;
        logic        is_branch;
        logic        is_jump;
        logic        is_reg;
        logic        is_alu;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] br_dest;
        logic [4:0]  dest;
        logic [2:0]  func3;
        logic        func7;
    } dec_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended from instr[31].
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr_i,
    output imm_t        imm_o
);

    logic sgn;
    assign sgn = instr_i[31];

    assign imm_o.i = {{20{sgn}}, instr_i[31:20]};
    assign imm_o.s = {{20{sgn}}, instr_i[31:25], instr_i[11:7]};
    assign imm_o.b = {{19{sgn}}, sgn, instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
    assign imm_o.j = {{11{sgn}}, sgn, instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
    assign imm_o.u = {instr_i[31:12], 12'b0};

endmodule

// File: rtl/rv32i_instr_decoder.sv
// RV32I decode stage: one-cycle registered decode of class flags and operands.
// Optional LUI/AUIPC decode is enabled by defining UPPER_IMM_EN.
module rv32i_instr_decoder
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic [4:0]      raddr1,
    output logic [4:0]      raddr2,
    output logic            is_store,
    output logic            is_load,
    output logic            is_branch,
    output logic            is_jump,
    output logic            is_reg,
    output logic            is_alu,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] branch_dest,
    output logic [4:0]      dest,
    output logic [2:0]      func3,
    output logic            func7
);

    imm_t imm;
    dec_t dec_d, dec_q;

    logic [6:0] opc;
    logic [4:0] rd;
    logic [2:0] f3;
    logic       is_shift;

    rv32i_imm_gen u_imm_gen (
        .instr_i (instr[31:7]),
        .imm_o   (imm)
    );

    // Read addresses must not leak an undefined instr into the file during reset.
    assign raddr1 = reset ? 5'd0 : instr[19:15];
    assign raddr2 = reset ? 5'd0 : instr[24:20];

    assign opc      = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);

`ifndef UPPER_IMM_EN
    logic unused_u;
    assign unused_u = ^imm.u;
`endif

    always_comb begin
        dec_d = '0;
        unique case (opc)
            OPC_JAL: begin
                dec_d.is_jump = 1'b1;
                dec_d.op_a    = imm.j;
                dec_d.br_dest = imm.j;
                dec_d.dest    = rd;
            end
            OPC_JALR: begin
                dec_d.is_jump = 1'b1;
                dec_d.is_reg  = 1'b1;
                dec_d.op_a    = rdata1;
                dec_d.op_b    = imm.i;
                dec_d.dest    = rd;
                dec_d.func3   = f3;
            end
            OPC_BRANCH: begin
                dec_d.is_branch = 1'b1;
                dec_d.op_a      = rdata1;
                dec_d.op_b      = rdata2;
                dec_d.br_dest   = imm.b;
                dec_d.func3     = f3;
            end
            OPC_LOAD: begin
                dec_d.is_load = 1'b1;
                dec_d.op_a    = rdata1;
                dec_d.op_b    = imm.i;
                dec_d.dest    = rd;
                dec_d.func3   = f3;
            end
            OPC_STORE: begin
                dec_d.is_store = 1'b1;
                dec_d.op_a     = rdata1;
                dec_d.op_b     = imm.s;
                dec_d.br_dest  = rdata2;
                dec_d.func3    = f3;
            end
            OPC_OPIMM: begin
                dec_d.is_alu = 1'b1;
                dec_d.op_a   = rdata1;
                dec_d.op_b   = is_shift ? {27'd0, instr[24:20]} : imm.i;
                dec_d.dest   = rd;
                dec_d.func3  = f3;
                dec_d.func7  = is_shift & instr[30];
            end
            OPC_OP: begin
                dec_d.is_alu = 1'b1;
                dec_d.op_a   = rdata1;
                dec_d.op_b   = rdata2;
                dec_d.dest   = rd;
                dec_d.func3  = f3;
                dec_d.func7  = instr[30];
            end
`ifdef UPPER_IMM_EN
            OPC_LUI: begin
                dec_d.is_alu = 1'b1;
                dec_d.op_b   = imm.u;
                dec_d.dest   = rd;
            end
            OPC_AUIPC: begin
                dec_d.is_alu  = 1'b1;
                dec_d.op_b    = imm.u;
                dec_d.br_dest = imm.u;
                dec_d.dest    = rd;
            end
`endif
            default: dec_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign is_store    = dec_q.is_store;
    assign is_load     = dec_q.is_load;
    assign is_branch   = dec_q.is_branch;
    assign is_jump     = dec_q.is_jump;
    assign is_reg      = dec_q.is_reg;
    assign is_alu      = dec_q.is_alu;
    assign operand_a   = dec_q.op_a;
    assign operand_b   = dec_q.op_b;
    assign branch_dest = dec_q.br_dest;
    assign dest        = dec_q.dest;
    assign func3       = dec_q.func3;
    assign func7       = dec_q.func7;

endmodule

// File: tb/tb_rv32i_instr_decoder.sv
// Scoreboard bench for rv32i_instr_decoder with directed instruction vectors.
module tb_rv32i_instr_decoder;

    typedef struct packed {
        logic [5:0]  flags;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] br;
        logic [4:0]  dest;
        logic [2:0]  f3;
        logic        f7;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] rdata1, rdata2;
    logic [4:0]  raddr1, raddr2;
    logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu;
    logic [31:0] operand_a, operand_b, branch_dest;
    logic [4:0]  dest;
    logic [2:0]  func3;
    logic        func7;

    logic [31:0] regs [32];
    logic        vld;
    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;

    rv32i_instr_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .is_store    (is_store),
        .is_load     (is_load),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .is_reg      (is_reg),
        .is_alu      (is_alu),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .branch_dest (branch_dest),
        .dest        (dest),
        .func3       (func3),
        .func7       (func7)
    );

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // flags = {store, load, branch, jump, reg, alu}
    function automatic exp_t mk(input logic [5:0] fl, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] br,
                                input logic [4:0] d, input logic [2:0] f3,
                                input logic f7);
        exp_t e;
        e.flags = fl; e.a = a; e.b = b; e.br = br;
        e.dest = d; e.f3 = f3; e.f7 = f7;
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input exp_t e,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        instr = ins;
        vld   = 1'b1;
        q.push_back(e);
        #1;
        chk("raddr1", {27'd0, raddr1}, {27'd0, ra1});
        chk("raddr2", {27'd0, raddr2}, {27'd0, ra2});
    endtask

    // Monitor: pops one expectation for every cycle a valid instr was presented.
    always @(posedge clk) begin
        logic s;
        exp_t e;
        s = vld;
        #1;
        if (s) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("flags", {26'd0, is_store, is_load, is_branch, is_jump,
                              is_reg, is_alu}, {26'd0, e.flags});
                chk("operand_a", operand_a, e.a);
                chk("operand_b", operand_b, e.b);
                chk("branch_dest", branch_dest, e.br);
                chk("dest", {27'd0, dest}, {27'd0, e.dest});
                chk("func3", {29'd0, func3}, {29'd0, e.f3});
                chk("func7", {31'd0, func7}, {31'd0, e.f7});
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3 + 1);
        vld   = 1'b0;
        reset = 1'b1;
        instr = 'x;
        @(posedge clk);
        @(negedge clk);
        chk("rst_raddr1", {27'd0, raddr1}, 32'd0);
        chk("rst_raddr2", {27'd0, raddr2}, 32'd0);
        chk("rst_flags", {26'd0, is_store, is_load, is_branch, is_jump,
                          is_reg, is_alu}, 32'd0);
        chk("rst_opa", operand_a, 32'd0);
        chk("rst_opb", operand_b, 32'd0);
        chk("rst_br", branch_dest, 32'd0);
        chk("rst_misc", {23'd0, dest, func3, func7}, 32'd0);
        instr = 32'h0000_0013;
        reset = 1'b0;

        issue(32'h7D0001EF, mk(6'b000100, 2000, 0, 2000, 3, 0, 0), 0, 16);
        regs[31] = 12345;
        issue(32'h7D0F8167, mk(6'b000110, 12345, 2000, 0, 2, 0, 0), 31, 16);
        regs[15] = 9876; regs[14] = 4567;
        issue(32'h7CE78863, mk(6'b001000, 9876, 4567, 2000, 0, 0, 0), 15, 14);
        regs[5] = 10;
        issue(32'h8302FF93, mk(6'b000001, 10, 32'hFFFF_F830, 0, 31, 7, 0), 5, 16);
        regs[3] = 5000;
        issue(32'h40A1D693, mk(6'b000001, 5000, 10, 0, 13, 5, 1), 3, 10);
        regs[20] = 900; regs[21] = 2000;
        issue(32'h015A0EB3, mk(6'b000001, 900, 2000, 0, 29, 0, 0), 20, 21);
        regs[2] = 100;
        issue(32'hFFC12083, mk(6'b010000, 100, 32'hFFFF_FFFC, 0, 1, 2, 0), 2, 28);
        regs[6] = 32'hDEAD_BEEF; regs[7] = 32'h1000;
        issue(32'h0063A423, mk(6'b100000, 32'h1000, 8, 32'hDEAD_BEEF, 0, 2, 0), 7, 6);
        regs[8] = 1;
        issue(32'h40040493, mk(6'b000001, 1, 1024, 0, 9, 0, 0), 8, 0);
        regs[11] = 7;
        issue(32'h01F59513, mk(6'b000001, 7, 31, 0, 10, 1, 0), 11, 31);
        regs[1] = 32'hFFFF_FFFD; regs[2] = 5;
        issue(32'hFE20CCE3, mk(6'b001000, 32'hFFFF_FFFD, 5, 32'hFFFF_FFF8, 0, 4, 0), 1, 2);
`ifdef UPPER_IMM_EN
        issue(32'h12345237, mk(6'b000001, 0, 32'h1234_5000, 0, 4, 0, 0), 8, 3);
        issue(32'h12345217, mk(6'b000001, 0, 32'h1234_5000, 32'h1234_5000, 4, 0, 0), 8, 3);
`else
        issue(32'h12345237, mk(6'b000000, 0, 0, 0, 0, 0, 0), 8, 3);
        issue(32'h12345217, mk(6'b000000, 0, 0, 0, 0, 0, 0), 8, 3);
`endif
        issue(32'h015A0EB3, mk(6'b000001, 900, 2000, 0, 29, 0, 0), 20, 21);
        @(negedge clk);
        vld = 1'b0;

        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);

        // Reload a nonzero decode, then assert reset between clock edges.
        instr = 32'h015A0EB3;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_alu", {31'd0, is_alu}, 32'd0);
        chk("async_opa", operand_a, 32'd0);
        chk("async_dest", {27'd0, dest}, 32'd0);
        chk("async_raddr1", {27'd0, raddr1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
